// File: rtl/redpi_pll_supervisor_pkg.sv
// Shared types and helpers for the PLL supervisor: state encoding and a
// compile-time max used to size the sequencing timer.
package redpi_pll_pkg;

   typedef enum logic [2:0] {
      RST_PLL   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      PWR_DN    = 3'd4,
      FAULT     = 3'd5
   } pll_sup_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/redpi_pll_supervisor_if.sv
// PLL-side pins, control requests and status of the supervisor.
// Level signals only: no valid/ready pairing; every output is a registered level.
interface redpi_pll_supervisor_if #(
   parameter int MAX_RETRY = 3
);
   localparam int RETRY_W = $clog2(MAX_RETRY + 1);

   logic               pll_locked;
   logic               pd_req;
   logic               fault_clr;
   logic               pll_rst;
   logic               pll_pwrdn;
   logic               sys_rstn;
   logic               clk_ok;
   logic               fault;
   logic [2:0]         state_o;
   logic [RETRY_W-1:0] retry_cnt;
   logic [7:0]         loss_cnt;

   modport master (
      input  pll_locked, pd_req, fault_clr,
      output pll_rst, pll_pwrdn, sys_rstn, clk_ok, fault, state_o, retry_cnt, loss_cnt
   );

   modport slave (
      output pll_locked, pd_req, fault_clr,
      input  pll_rst, pll_pwrdn, sys_rstn, clk_ok, fault, state_o, retry_cnt, loss_cnt
   );
endinterface

// File: rtl/redpi_pll_supervisor_sync2.sv
// Two-flop synchroniser with synchronous active-low reset to RESET_VAL.
module redpi_sync2 #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rstn,
   input  logic i_d,
   output logic o_q
);
   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;
endmodule

// File: rtl/redpi_pll_supervisor.sv
// PLL start-up/lock supervisor: sequences PLL reset and power-down, qualifies
// lock over a stability window and gates the downstream system reset.
module redpi_pll_supervisor
   import redpi_pll_pkg::*;
#(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 65536,
   parameter int STABLE_CYCLES = 1024,
   parameter int LOSS_FILTER   = 4,
   parameter int MAX_RETRY     = 3
) (
   input  logic                  clk_in,
   input  logic                  rstn,
   redpi_pll_supervisor_if.master sup_if
);
   localparam int TMR_W   = $clog2(max3(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES)) + 1;
   localparam int RETRY_W = $clog2(MAX_RETRY + 1);
   localparam int LF_W    = $clog2(LOSS_FILTER + 1);

   pll_sup_state_t     r_state, w_next;
   logic [TMR_W-1:0]   r_timer, w_timer, w_tmr_inc;
   logic [RETRY_W-1:0] r_retry, w_retry;
   logic [7:0]         r_loss, w_loss;
   logic [LF_W-1:0]    r_lflt, w_lflt;
   logic               r_pll_rst, r_pwrdn, r_sys_rstn, r_clk_ok, r_fault;
   logic               w_locked_s;

   redpi_sync2 #(.RESET_VAL(1'b0)) u_sync (
      .i_clk  (clk_in),
      .i_rstn (rstn),
      .i_d    (sup_if.pll_locked),
      .o_q    (w_locked_s)
   );

   // Timer saturates instead of wrapping.
   assign w_tmr_inc = (r_timer == {TMR_W{1'b1}}) ? r_timer : r_timer + 1'b1;

   always_comb begin
      w_next  = r_state;
      w_timer = r_timer;
      w_retry = r_retry;
      w_loss  = r_loss;
      w_lflt  = '0;
      if (sup_if.pd_req && (r_state inside {RST_PLL, WAIT_LOCK, STABLE, RUN})) begin
         w_next  = PWR_DN;
         w_timer = '0;
      end else begin
         case (r_state)
            RST_PLL: begin
               if (r_timer == TMR_W'(RST_CYCLES - 1)) begin
                  w_next  = WAIT_LOCK;
                  w_timer = '0;
               end else begin
                  w_timer = w_tmr_inc;
               end
            end
            WAIT_LOCK: begin
               if (w_locked_s) begin
                  w_next  = STABLE;
                  w_timer = '0;
               end else if (r_timer == TMR_W'(LOCK_TIMEOUT - 1)) begin
                  w_timer = '0;
                  w_retry = r_retry + 1'b1;
                  w_next  = (w_retry == RETRY_W'(MAX_RETRY)) ? FAULT : RST_PLL;
               end else begin
                  w_timer = w_tmr_inc;
               end
            end
            STABLE: begin
               // The locked cycle that entered STABLE is the first of the window.
               if (!w_locked_s) begin
                  w_next  = WAIT_LOCK;
                  w_timer = '0;
               end else if (r_timer == TMR_W'(STABLE_CYCLES - 2)) begin
                  w_next  = RUN;
                  w_timer = '0;
                  w_retry = '0;
               end else begin
                  w_timer = w_tmr_inc;
               end
            end
            RUN: begin
               if (!w_locked_s) begin
                  if (r_lflt == LF_W'(LOSS_FILTER - 1)) begin
                     w_next  = RST_PLL;
                     w_timer = '0;
                     w_loss  = (r_loss == 8'hFF) ? r_loss : r_loss + 8'd1;
                  end else begin
                     w_lflt = r_lflt + 1'b1;
                  end
               end
            end
            PWR_DN: begin
               if (!sup_if.pd_req) begin
                  w_next  = RST_PLL;
                  w_timer = '0;
                  w_retry = '0;
               end
            end
            FAULT: begin
               if (sup_if.fault_clr) begin
                  w_next  = RST_PLL;
                  w_timer = '0;
                  w_retry = '0;
               end
            end
            default: begin
               w_next  = RST_PLL;
               w_timer = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rstn) begin
         r_state    <= RST_PLL;
         r_timer    <= '0;
         r_retry    <= '0;
         r_loss     <= '0;
         r_lflt     <= '0;
         r_pll_rst  <= 1'b1;
         r_pwrdn    <= 1'b0;
         r_sys_rstn <= 1'b0;
         r_clk_ok   <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_timer    <= w_timer;
         r_retry    <= w_retry;
         r_loss     <= w_loss;
         r_lflt     <= w_lflt;
         r_pll_rst  <= (w_next == RST_PLL) || (w_next == PWR_DN) || (w_next == FAULT);
         r_pwrdn    <= (w_next == PWR_DN);
         r_sys_rstn <= (w_next == RUN);
         r_clk_ok   <= (w_next == RUN);
         r_fault    <= (w_next == FAULT);
      end
   end

   assign sup_if.pll_rst   = r_pll_rst;
   assign sup_if.pll_pwrdn = r_pwrdn;
   assign sup_if.sys_rstn  = r_sys_rstn;
   assign sup_if.clk_ok    = r_clk_ok;
   assign sup_if.fault     = r_fault;
   assign sup_if.state_o   = r_state;
   assign sup_if.retry_cnt = r_retry;
   assign sup_if.loss_cnt  = r_loss;
endmodule
